// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-client arbiter: opcodes, FSM encoding, width default.
package alu_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOTA = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    // Opcodes 110 and 111 have no operation behind them.
    function automatic logic op_is_illegal(logic [2:0] sel);
        return sel > OP_NOTA;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Client request channels and response channel of the shared-ALU arbiter.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [2:0]        req0_sel;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [2:0]        req1_sel;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_carry;
    logic              rsp_err;
    logic              busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        input  req1_valid, req1_a, req1_b, req1_sel,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        output req1_valid, req1_a, req1_b, req1_sel,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err, busy
    );
endinterface

// File: rtl/alu.sv
// Combinational 6-operation ALU. SUB reports a borrow (a < b) on carry_out; illegal opcodes give 0.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        sel,
    output logic [DATA_W-1:0] result,
    output logic              carry_out
);
    logic [DATA_W:0] wide;

    always_comb begin
        wide      = '0;
        result    = '0;
        carry_out = 1'b0;
        case (sel)
            OP_ADD: begin
                wide      = {1'b0, a} + {1'b0, b};
                result    = wide[DATA_W-1:0];
                carry_out = wide[DATA_W];
            end
            OP_SUB: begin
                wide      = {1'b0, a} - {1'b0, b};
                result    = wide[DATA_W-1:0];
                carry_out = wide[DATA_W];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOTA: result = ~a;
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two clients: IDLE grants, EXEC computes, RESP returns.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    state_e            state_q, state_d;
    logic              rr_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [2:0]        sel_q;
    logic              id_q;

    logic [DATA_W-1:0] rsp_result_q;
    logic              rsp_carry_q, rsp_err_q, rsp_id_q;

    logic              any_valid, grant_id, accept;
    logic [DATA_W-1:0] grant_a, grant_b;
    logic [2:0]        grant_sel;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        // Tie goes to the round-robin pointer; a lone requester always wins.
        grant_id  = (bus.req0_valid && bus.req1_valid) ? rr_q : bus.req1_valid;
        accept    = rst_n && (state_q == StIdle) && any_valid;
        grant_a   = grant_id ? bus.req1_a   : bus.req0_a;
        grant_b   = grant_id ? bus.req1_b   : bus.req0_b;
        grant_sel = grant_id ? bus.req1_sel : bus.req0_sel;
    end

    assign bus.req0_ready = accept && !grant_id;
    assign bus.req1_ready = accept &&  grant_id;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_valid) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (bus.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Operands reach the ALU only through the latched registers.
    alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a         (a_q),
        .b         (b_q),
        .sel       (sel_q),
        .result    (alu_result),
        .carry_out (alu_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            rr_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= '0;
            id_q         <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q   <= grant_a;
                b_q   <= grant_b;
                sel_q <= grant_sel;
                id_q  <= grant_id;
                rr_q  <= ~grant_id;
            end
            if (state_q == StExec) begin
                rsp_result_q <= op_is_illegal(sel_q) ? '0 : alu_result;
                rsp_carry_q  <= op_is_illegal(sel_q) ? 1'b0 : alu_carry;
                rsp_err_q    <= op_is_illegal(sel_q);
                rsp_id_q     <= id_q;
            end
        end
    end

    assign bus.rsp_valid  = (state_q == StResp);
    assign bus.busy       = (state_q != StIdle);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios followed by randomized two-client traffic.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct {
        logic       id;
        logic [7:0] res;
        logic       carry;
        logic       err;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_arbiter_if #(.DATA_W(8)) bus ();

    alu_arbiter #(.DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   hs_count = 0;
    int   drv_done = 0;
    exp_t sbq[$];
    bit   grant_log[$];
    bit   mbusy = 0, mrr = 0, prev_valid = 0, rst_prev = 0;
    logic [7:0] hold_res, last_res;
    logic       hold_id, hold_carry, hold_err, last_id, last_carry, last_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour from the opcode table, in plain integer arithmetic.
    function automatic exp_t model(bit id, logic [7:0] a, logic [7:0] b, logic [2:0] sel,
                                   int c);
        exp_t e;
        int ia = int'(a);
        int ib = int'(b);
        e.id = id; e.cyc = c; e.res = 8'h00; e.carry = 1'b0; e.err = 1'b0;
        case (sel)
            3'd0: begin e.res = 8'((ia + ib) % 256); e.carry = (ia + ib) > 255; end
            3'd1: begin e.res = 8'((ia - ib + 256) % 256); e.carry = ia < ib; end
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd4: e.res = a ^ b;
            3'd5: e.res = ~a;
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // Monitor: arbitration expectations, latency, stability and scoreboard pops.
    always @(negedge clk) begin
        bit   er0, er1;
        exp_t e;
        cyc++;
        if (rst_prev) begin
            chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'(0));
            chk("reset_busy", 32'(bus.busy), 32'(0));
            chk("reset_rsp_id", 32'(bus.rsp_id), 32'(0));
            chk("reset_rsp_result", 32'(bus.rsp_result), 32'(0));
            chk("reset_rsp_carry", 32'(bus.rsp_carry), 32'(0));
            chk("reset_rsp_err", 32'(bus.rsp_err), 32'(0));
        end
        if (!rst_n) begin
            chk("reset_ready0", 32'(bus.req0_ready), 32'(0));
            chk("reset_ready1", 32'(bus.req1_ready), 32'(0));
            sbq.delete();
            grant_log.delete();
            mbusy = 0; mrr = 0; prev_valid = 0; rst_prev = 1;
        end else begin
            rst_prev = 0;
            er0 = 0; er1 = 0;
            if (!mbusy) begin
                if (bus.req0_valid && bus.req1_valid) begin
                    if (mrr) er1 = 1; else er0 = 1;
                end else if (bus.req0_valid) er0 = 1;
                else if (bus.req1_valid) er1 = 1;
            end
            chk("ready0", 32'(bus.req0_ready), 32'(er0));
            chk("ready1", 32'(bus.req1_ready), 32'(er1));
            chk("busy", 32'(bus.busy), 32'(mbusy));
            if (bus.req0_valid && bus.req0_ready) begin
                sbq.push_back(model(0, bus.req0_a, bus.req0_b, bus.req0_sel, cyc));
                grant_log.push_back(0); mrr = 1; mbusy = 1;
            end
            if (bus.req1_valid && bus.req1_ready) begin
                sbq.push_back(model(1, bus.req1_a, bus.req1_b, bus.req1_sel, cyc));
                grant_log.push_back(1); mrr = 0; mbusy = 1;
            end
            if (bus.rsp_valid) begin
                if (!prev_valid) begin
                    if (sbq.size() == 0) chk("unexpected_rsp_valid", 32'(1), 32'(0));
                    else chk("latency", 32'(cyc - sbq[0].cyc), 32'(2));
                    hold_res = bus.rsp_result; hold_id = bus.rsp_id;
                    hold_carry = bus.rsp_carry; hold_err = bus.rsp_err;
                end else begin
                    chk("stable_result", 32'(bus.rsp_result), 32'(hold_res));
                    chk("stable_id", 32'(bus.rsp_id), 32'(hold_id));
                    chk("stable_carry", 32'(bus.rsp_carry), 32'(hold_carry));
                    chk("stable_err", 32'(bus.rsp_err), 32'(hold_err));
                end
                if (bus.rsp_ready && sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("rsp_result", 32'(bus.rsp_result), 32'(e.res));
                    chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                    chk("rsp_carry", 32'(bus.rsp_carry), 32'(e.carry));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    last_res = bus.rsp_result; last_id = bus.rsp_id;
                    last_carry = bus.rsp_carry; last_err = bus.rsp_err;
                    hs_count++;
                    mbusy = 0;
                end
            end
            prev_valid = bus.rsp_valid;
        end
    end

    task automatic issue(input bit k, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] sel);
        int n = 0;
        if (!k) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_sel = sel; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_sel = sel; bus.req1_valid = 1'b1;
        end
        forever begin
            @(negedge clk);
            if (rst_n && (k ? bus.req1_ready : bus.req0_ready)) break;
            n++;
            if (n > 300) begin
                n_checks++; n_err++;
                $display("FAIL grant_timeout: client %0d got no ready, required one", k);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!k) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (sbq.size() == 0 && !mbusy) begin
                #1;
                return;
            end
        end
        n_checks++; n_err++;
        $display("FAIL idle_timeout: %0d responses outstanding, required 0", sbq.size());
        #1;
    endtask

    task automatic check_last(input string nm, input logic [7:0] r, input logic c,
                              input logic id, input logic err);
        chk({nm, "_result"}, 32'(last_res), 32'(r));
        chk({nm, "_carry"}, 32'(last_carry), 32'(c));
        chk({nm, "_id"}, 32'(last_id), 32'(id));
        chk({nm, "_err"}, 32'(last_err), 32'(err));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_sel = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_sel = 0;
        bus.rsp_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        issue(0, 8'h0F, 8'h01, OP_ADD);
        wait_idle();
        check_last("add", 8'h10, 1'b0, 1'b0, 1'b0);

        issue(1, 8'hFF, 8'h01, OP_ADD);
        wait_idle();
        check_last("add_ovf", 8'h00, 1'b1, 1'b1, 1'b0);

        // Contention with both clients valid from inside reset.
        rst_n = 0;
        fork
            begin issue(0, 8'hAA, 8'hCC, OP_AND); issue(0, 8'hAA, 8'hCC, OP_AND); end
            begin issue(1, 8'hAA, 8'hCC, OP_XOR); issue(1, 8'hAA, 8'hCC, OP_XOR); end
            begin repeat (2) @(posedge clk); #1 rst_n = 1; end
        join
        wait_idle();
        chk("grant_count", 32'(grant_log.size()), 32'(4));
        for (int i = 0; i < grant_log.size() && i < 4; i++)
            chk("grant_order", 32'(grant_log[i]), 32'(i % 2));

        // Backpressure on a NOT A response with client 1 waiting behind it.
        bus.rsp_ready = 0;
        fork
            issue(0, 8'hAA, 8'h00, OP_NOTA);
            begin repeat (2) @(posedge clk); #1; issue(1, 8'h0F, 8'h01, OP_ADD); end
            begin
                int n = 0;
                while (!bus.rsp_valid && n < 50) begin @(posedge clk); n++; end
                chk("bp_rsp_seen", 32'(bus.rsp_valid), 32'(1));
                hs0 = hs_count;
                repeat (5) @(posedge clk);
                #1 bus.rsp_ready = 1;
                @(negedge clk);
                #1;
                chk("bp_single_handshake", 32'(hs_count - hs0), 32'(1));
                check_last("nota", 8'h55, 1'b0, 1'b0, 1'b0);
            end
        join
        wait_idle();
        check_last("after_bp", 8'h10, 1'b0, 1'b1, 1'b0);

        issue(1, 8'h12, 8'h34, 3'b111);
        wait_idle();
        check_last("illegal", 8'h00, 1'b0, 1'b1, 1'b1);
        issue(0, 8'hAA, 8'hCC, OP_OR);
        wait_idle();
        check_last("or", 8'hEE, 1'b0, 1'b0, 1'b0);

        // Reset while EXEC holds a client 0 op (pointer now favours client 1).
        hs0 = hs_count;
        issue(0, 8'h01, 8'h02, OP_ADD);
        rst_n = 0;
        @(posedge clk);
        #1 rst_n = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_exec_no_rsp", 32'(hs_count - hs0), 32'(0));
        fork
            issue(0, 8'h05, 8'h03, OP_SUB);
            issue(1, 8'h03, 8'h05, OP_SUB);
        join
        wait_idle();
        chk("rst_rr_first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : 1'b1), 32'(0));

        // Randomized traffic with random response backpressure.
        drv_done = 0;
        fork
            for (int k = 0; k < 2; k++) begin
                automatic int kk = k;
                fork
                    begin
                        repeat (30) begin
                            int gap = $urandom_range(0, 3);
                            if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
                            issue(kk[0], 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
                        end
                        drv_done++;
                    end
                join_none
            end
            while (drv_done < 2) begin
                @(posedge clk);
                #1 bus.rsp_ready = ($urandom_range(0, 9) < 7);
            end
        join
        bus.rsp_ready = 1;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer that shares a single instance of the team's 8-bit, 6-operation `alu` between two independent clients. Each client issues an operation (operands A, B and a 3-bit opcode) over a valid/ready handshake. The arbiter grants one client, latches its operands, drives the ALU, registers the result and returns it with the winner's ID over a valid/ready response channel. It sits between client FSMs and the shared combinational ALU.

## Interface
- `DATA_W`, 8, operand/result width; must equal the `alu` width.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `req0_valid` input 1: client 0 has an operation pending.
- `req0_ready` output 1: client 0 operation accepted this cycle.
- `req0_a` input DATA_W: client 0 operand A.
- `req0_b` input DATA_W: client 0 operand B.
- `req0_sel` input 3: client 0 opcode.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sel`: same as client 0, for client 1.
- `rsp_valid` output 1: response available.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_id` output 1: ID of the client that issued the operation.
- `rsp_result` output DATA_W: ALU result.
- `rsp_carry` output 1: ALU `carry_out`.
- `rsp_err` output 1: opcode was illegal (110 or 111).
- `busy` output 1: high whenever state is not IDLE.

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A. For all legal opcodes, `carry_out` passes through unchanged from `alu`.
- Illegal opcodes (110, 111) still take the normal path. The response has `rsp_result`=0, `rsp_carry`=0, `rsp_err`=1.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if any `reqN_valid` is high, grant one client, latch its A/B/sel/ID, then go to EXEC.
  - EXEC: the ALU is driven from the latched registers. At the clock edge, the result, carry, err and ID are registered into the `rsp_*` outputs, and the FSM goes to RESP.
  - RESP: `rsp_valid`=1. Hold all `rsp_*` outputs stable until `rsp_valid && rsp_ready`, then go to IDLE.
- Arbitration:
  - Round-robin pointer `rr`, reset to 0.
  - If only one client is valid, that client wins.
  - If both are valid, client `rr` wins.
  - After any accepted grant, `rr` becomes the other client's ID.
- `reqN_ready` is combinational: high only in IDLE for the granted client. At most one ready is high per cycle.
- Client rules: once `reqN_valid` is asserted, the client holds it and its operand/opcode fields stable until ready. Valid must not depend on ready.
- The ALU is never driven directly from client ports. Its inputs come only from the latched registers.

## Timing
- Reset values: state IDLE, `rr`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_carry`=0, `rsp_err`=0, `busy`=0. Both `reqN_ready` are 0 during reset.
- Latency: request accepted in cycle N (ready & valid), `rsp_valid` first high in cycle N+2.
- Throughput: with `rsp_ready` tied high, the minimum accept-to-accept spacing is 3 cycles (N, N+3, ...).
- No new grant is issued in RESP or EXEC. A request arriving then waits, with ready low.
- Backpressure: `rsp_ready` low in RESP stalls indefinitely. Outputs stay frozen, and no request is accepted.
- Reset mid-operation: on any edge with `rst_n`=0, the in-flight operation and any pending response are discarded. All outputs return to reset values at that edge.
- Simultaneous request in the cycle that RESP completes: it is not granted until the following IDLE cycle.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams `OP_ADD` through `OP_NOTA`;
  - FSM state encoding (2 bits);
  - `DATA_W` default.
- One sub-module: the existing `alu`, instantiated once, inputs from latched registers, outputs sampled in EXEC.
- Arbiter, FSM and response registers live in `alu_arbiter`. No further sub-modules.

## Test plan
- Reset then single ADD: client 0, A=0x0F, B=0x01, sel=000, `rsp_ready`=1.
  - Expect ready in cycle N.
  - Expect `rsp_valid` in N+2 with result 0x10, carry 0, id 0, err 0.
- ADD overflow: client 1, A=0xFF, B=0x01, sel=000.
  - Expect result 0x00, carry 1, id 1.
- Contention: both clients valid continuously from reset. Client 0 does AND 0xAA,0xCC; client 1 does XOR 0xAA,0xCC.
  - Expect grants in order 0,1,0,1.
  - Expect responses 0x88 (id 0) and 0x66 (id 1), alternating.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP with result 0x55 from NOT A on 0xAA.
  - Expect `rsp_*` stable and both readies low throughout.
  - Expect a single handshake when `rsp_ready` rises.
- Illegal opcode: sel=111.
  - Expect `rsp_err`=1, result 0x00, carry 0.
  - The next legal op (OR 0xAA,0xCC) returns 0xEE, err 0.
- Reset during EXEC: assert `rst_n`=0 for one cycle while EXEC is active.
  - Expect `rsp_valid` to never rise for that op and `busy`=0 after the edge.
  - Expect the next request to be granted to client 0 (`rr`=0).
